// File: rtl/fifo_pair_arbiter.sv
// fifo_pair_arbiter: pops two FWFT fifos into one registered valid/ready stream, bounded-burst alternating.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed A-over-B priority (no burst state).
module fifo_pair_arbiter #(
  parameter int DWIDTH     = 16,
  parameter int BURST_MAX  = 4,
  parameter int BURST_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_empty,
  input  logic [DWIDTH-1:0] a_dout,
  output logic              a_rd_en,
  input  logic              b_empty,
  input  logic [DWIDTH-1:0] b_dout,
  output logic              b_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_src,
  output logic              busy
);
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              load, grant_a, grant_b;
`ifdef FIFO_ARB_STRICT_PRIO_EN
  always_comb begin
    grant_a = ~a_empty;
    grant_b = ~b_empty & a_empty;
  end
`else
  localparam logic [0:0] SERVE_A = 1'b0;
  localparam logic [0:0] SERVE_B = 1'b1;
  localparam logic [BURST_BITS-1:0] BMAX = BURST_BITS'(BURST_MAX);
  logic [0:0]            state_q, state_d;
  logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;
  logic                  under, serve_b, own_ok, pop;
  // own_ok: the served fifo may keep going (burst budget left, or the other side has nothing)
  always_comb begin
    under = burst_cnt_q < BMAX;
    serve_b = state_q == SERVE_B;
    own_ok = under | (serve_b ? a_empty : b_empty);
    grant_b = serve_b ? ~b_empty & own_ok : ~b_empty & ~(~a_empty & own_ok);
    grant_a = serve_b ? ~a_empty & ~(~b_empty & own_ok) : ~a_empty & own_ok;
    pop = a_rd_en | b_rd_en;
    state_d = pop ? b_rd_en : state_q;
    burst_cnt_d = ~pop ? burst_cnt_q :
                  (b_rd_en != state_q) ? BURST_BITS'(1) :
                  under ? burst_cnt_q + BURST_BITS'(1) : burst_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE_A;
      burst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif
  always_comb begin
    load = ~out_valid_q | out_ready;
    a_rd_en = ~rst & load & grant_a;
    b_rd_en = ~rst & load & grant_b;
    out_valid_d = load ? (a_rd_en | b_rd_en) : out_valid_q;
    out_data_d = a_rd_en ? a_dout : b_rd_en ? b_dout : out_data_q;
    out_src_d = a_rd_en ? 1'b0 : b_rd_en ? 1'b1 : out_src_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_src = out_src_q;
  assign busy = out_valid_q | ~a_empty | ~b_empty;
endmodule

// File: tb/tb_fifo_pair_arbiter.sv
// tb_fifo_pair_arbiter: queue-based fifo environment plus a run-length arbitration model checked every cycle.
module tb_fifo_pair_arbiter;
  localparam int DW = 16;
  localparam int BMAX = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_empty = 1'b1, b_empty = 1'b1, out_ready = 1'b1;
  logic [DW-1:0] a_dout = '0, b_dout = '0;
  logic          a_rd_en, b_rd_en, out_valid, out_src, busy;
  logic [DW-1:0] out_data;
  fifo_pair_arbiter #(.DWIDTH(DW), .BURST_MAX(BMAX), .BURST_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .a_empty(a_empty), .a_dout(a_dout), .a_rd_en(a_rd_en),
    .b_empty(b_empty), .b_dout(b_dout), .b_rd_en(b_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] qa[$], qb[$], ma[$], mb[$];
  logic [DW:0]   log_q[$];
  int            log_cyc[$];
  logic          m_valid, m_src;
  logic [DW-1:0] m_data;
  int            m_last, m_run, cyc, n_cmp, n_err;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic push_a(input logic [DW-1:0] v);
    qa.push_back(v);
    ma.push_back(v);
  endtask
  task automatic push_b(input logic [DW-1:0] v);
    qb.push_back(v);
    mb.push_back(v);
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_data = '0;
    m_src = 1'b0;
    m_last = 1;
    m_run = 0;
  endtask
  // pick: 0 none, 1 A, 2 B; stay with the last source until it has run BMAX times while the other waits
  function automatic int pick_src();
    int p;
    p = 0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
    p = (ma.size() != 0) ? 1 : (mb.size() != 0) ? 2 : 0;
`else
    if (ma.size() != 0 && mb.size() != 0) p = (m_run >= BMAX) ? 3 - m_last : m_last;
    else if (ma.size() != 0) p = 1;
    else if (mb.size() != 0) p = 2;
`endif
    return p;
  endfunction
  task automatic step();
    logic ld;
    int p;
    a_empty = qa.size() == 0;
    b_empty = qb.size() == 0;
    a_dout = (qa.size() != 0) ? qa[0] : '0;
    b_dout = (qb.size() != 0) ? qb[0] : '0;
    @(negedge clk);
    ld = !m_valid || out_ready;
    p = pick_src();
    chk("a_rd_en", 32'(a_rd_en), 32'(!rst && ld && p == 1));
    chk("b_rd_en", 32'(b_rd_en), 32'(!rst && ld && p == 2));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    if (m_valid) chk("out_src", 32'(out_src), 32'(m_src));
    chk("busy", 32'(busy), 32'(m_valid || qa.size() != 0 || qb.size() != 0));
    if (out_valid && out_ready && !rst) begin
      log_q.push_back({out_src, out_data});
      log_cyc.push_back(cyc);
    end
    if (rst) model_reset();
    else if (ld) begin
      m_valid = p != 0;
      if (p != 0) begin
        m_data = (p == 1) ? ma.pop_front() : mb.pop_front();
        m_src = p == 2;
        m_run = (p == m_last) ? m_run + 1 : 1;
        m_last = p;
      end
    end
    if (a_rd_en && qa.size() != 0) void'(qa.pop_front());
    if (b_rd_en && qb.size() != 0) void'(qb.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    logic [15:0] pat;
    logic [DW-1:0] ev;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (5) step();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_rd", 32'({a_rd_en, b_rd_en}), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_data", 32'(out_data), 32'h0);
    // A only
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push_a(DW'(i));
    log_q.delete();
    repeat (10) step();
    chk("a_only_count", log_q.size(), 6);
    for (int i = 0; i < log_q.size() && i < 6; i++) chk("a_only_word", 32'(log_q[i]), 32'(i + 1));
    // both full, continuous ready
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_a(DW'(16'hA000 + i));
      push_b(DW'(16'hB000 + i));
    end
    log_q.delete();
    repeat (20) step();
    pat = '0;
    foreach (log_q[i]) pat = {pat[14:0], log_q[i][DW]};
    chk("fair_count", log_q.size(), 16);
`ifdef FIFO_ARB_STRICT_PRIO_EN
    chk("fair_pattern", 32'(pat), 32'h00FF);
`else
    chk("fair_pattern", 32'(pat), 32'b0000111100001111);
    if (log_q.size() == 16) begin
      chk("fair_first_b", 32'(log_q[4][DW-1:0]), 32'hB000);
      chk("fair_last", 32'(log_q[15][DW-1:0]), 32'hB007);
    end
`endif
    // both full, ready toggled 1,0,0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_a(DW'(16'hA000 + i));
      push_b(DW'(16'hB000 + i));
    end
    log_q.delete();
    for (int k = 0; k < 80; k++) begin
      out_ready = (k % 3) == 0;
      step();
    end
    out_ready = 1'b1;
    chk("stall_count", log_q.size(), 16);
    for (int k = 0; k < log_q.size() && k < 16; k++) begin
`ifdef FIFO_ARB_STRICT_PRIO_EN
      ev = (k < 8) ? DW'(16'hA000 + k) : DW'(16'hB000 + k - 8);
`else
      ev = DW'(((k % 8) < 4 ? 16'hA000 : 16'hB000) + (k / 8) * 4 + (k % 4));
`endif
      chk("stall_word", 32'(log_q[k][DW-1:0]), 32'(ev));
    end
    // A runs dry mid-burst
    do_reset();
    push_a(16'hA000);
    push_a(16'hA001);
    for (int i = 0; i < 3; i++) push_b(DW'(16'hB000 + i));
    log_q.delete();
    log_cyc.delete();
    repeat (8) step();
    chk("dry_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("dry_src", 32'({log_q[0][DW], log_q[1][DW], log_q[2][DW], log_q[3][DW], log_q[4][DW]}), 32'b00111);
      chk("dry_no_bubble", log_cyc[4] - log_cyc[0], 4);
      chk("dry_b0", 32'(log_q[2][DW-1:0]), 32'hB000);
    end
    // reset while holding a word
    do_reset();
    out_ready = 1'b0;
    push_b(16'hBEEF);
    push_b(16'hB001);
    step();
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_data", 32'(out_data), 32'hBEEF);
    push_a(16'hA100);
    do_reset();
    chk("rst_drop_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    log_q.delete();
    repeat (6) step();
    chk("resume_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("resume_first", 32'(log_q[0]), 32'({1'b0, 16'hA100}));
      chk("resume_second", 32'(log_q[1]), 32'({1'b1, 16'hB001}));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
